// File: rtl/concat_stream.sv
// Packs a stream of DATAW_IN-bit beats into DATAW_OUT-bit words with valid/ready
// on both sides, early close via in_last, per-lane keep and selectable lane order.
module concat_stream #(
   parameter int unsigned DATAW_IN  = 8,
   parameter int unsigned DATAW_OUT = 32,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATAW_IN-1:0]               in_data,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATAW_OUT-1:0]              out_data,
   output logic [DATAW_OUT/DATAW_IN-1:0]     out_keep,
   output logic                              out_last
);

   localparam int unsigned LANES = DATAW_OUT / DATAW_IN;
   localparam int unsigned CW    = (LANES > 1) ? $clog2(LANES) : 1;

   if ((DATAW_OUT % DATAW_IN) != 0 || LANES < 2) begin : g_bad_params
      $error("concat_stream: DATAW_OUT must be an integer multiple (>=2) of DATAW_IN");
   end

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATAW_OUT-1:0] buf_q, buf_d;
   logic                 out_valid_q, out_valid_d;
   logic [DATAW_OUT-1:0] out_data_q, out_data_d;
   logic [LANES-1:0]     out_keep_q, out_keep_d;
   logic                 out_last_q, out_last_d;

   logic                 close_pending;
   logic                 accept;
   logic [CW-1:0]        lane_idx;
   logic [DATAW_OUT-1:0] word;
   logic [DATAW_OUT-1:0] word_masked;
   logic [LANES-1:0]     keep_lsb;
   logic [LANES-1:0]     keep;

   always_comb begin
      close_pending = (cnt_q == CW'(LANES - 1)) | in_last;
      in_ready      = ~out_valid_q | out_ready | ~close_pending;
      accept        = in_valid & in_ready;
      lane_idx      = LSB_FIRST ? cnt_q : (CW'(LANES - 1) - cnt_q);

      word = buf_q;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (CW'(i) == lane_idx) word[i*DATAW_IN +: DATAW_IN] = in_data;
      end

      // Keep is built in arrival order then mirrored, so it always marks the lanes
      // actually written; lanes beyond the close point are zeroed in the data.
      for (int unsigned i = 0; i < LANES; i++) begin
         keep_lsb[i] = (CW'(i) <= cnt_q);
      end
      for (int unsigned i = 0; i < LANES; i++) begin
         keep[i] = LSB_FIRST ? keep_lsb[i] : keep_lsb[LANES-1-i];
      end
      for (int unsigned i = 0; i < LANES; i++) begin
         word_masked[i*DATAW_IN +: DATAW_IN] = keep[i] ? word[i*DATAW_IN +: DATAW_IN] : '0;
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         if (close_pending) begin
            out_valid_d = 1'b1;
            out_data_d  = word_masked;
            out_keep_d  = keep;
            out_last_d  = in_last;
            cnt_d       = '0;
            buf_d       = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
            buf_d = word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         buf_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_concat_stream.sv
// Directed self-checking bench for concat_stream (8->32), with an LSB_FIRST=1 and
// an LSB_FIRST=0 instance fed from the same input stream.
module tb_concat_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready, out_valid, out_last;
   logic [31:0] out_data;
   logic [3:0]  out_keep;

   logic        m_in_ready, m_out_valid, m_out_last;
   logic [31:0] m_out_data;
   logic [3:0]  m_out_keep;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   concat_stream #(.DATAW_IN(8), .DATAW_OUT(32), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
      .out_last(out_last)
   );

   concat_stream #(.DATAW_IN(8), .DATAW_OUT(32), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(m_out_valid),
      .out_ready(out_ready), .out_data(m_out_data), .out_keep(m_out_keep),
      .out_last(m_out_last)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; idle(); out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got=%h exp=00000000", out_data); end
      n_cmp++; if (out_keep !== 4'b0000) begin n_err++; $display("FAIL rst_out_keep got=%b exp=0000", out_keep); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      @(posedge clk); #3 rst_n = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_full_word();
      logic [7:0] beats [4];
      int unsigned rdy_drops;
      beats = '{8'h11, 8'h22, 8'h33, 8'h44};
      rdy_drops = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(beats[i], 1'b0);
         #1;
         if (in_ready !== 1'b1) rdy_drops++;
         tick();
         if (i == 2) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid got=%b exp=0", out_valid); end
         end
      end
      idle();
      n_cmp++; if (rdy_drops != 0) begin n_err++; $display("FAIL full_in_ready_drops got=%0d exp=0", rdy_drops); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid got=%b exp=1", out_valid); end
      n_cmp++; if (out_data !== 32'h44332211) begin n_err++; $display("FAIL full_data_lsb got=%h exp=44332211", out_data); end
      n_cmp++; if (out_keep !== 4'b1111) begin n_err++; $display("FAIL full_keep got=%b exp=1111", out_keep); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL full_last got=%b exp=0", out_last); end
      n_cmp++; if (m_out_data !== 32'h11223344) begin n_err++; $display("FAIL full_data_msb got=%h exp=11223344", m_out_data); end
      n_cmp++; if (m_out_keep !== 4'b1111) begin n_err++; $display("FAIL full_keep_msb got=%b exp=1111", m_out_keep); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drain_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_keep !== 4'b1111) begin n_err++; $display("FAIL full_drain_keep_hold got=%b exp=1111", out_keep); end
   endtask

   task automatic test_last();
      out_ready = 1'b1;
      drive(8'hAA, 1'b0); tick();
      drive(8'hBB, 1'b1); tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL last_valid got=%b exp=1", out_valid); end
      n_cmp++; if (out_data !== 32'h0000BBAA) begin n_err++; $display("FAIL last_data got=%h exp=0000bbaa", out_data); end
      n_cmp++; if (out_keep !== 4'b0011) begin n_err++; $display("FAIL last_keep got=%b exp=0011", out_keep); end
      n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL last_last got=%b exp=1", out_last); end
      n_cmp++; if (m_out_data !== 32'hAABB0000) begin n_err++; $display("FAIL last_data_msb got=%h exp=aabb0000", m_out_data); end
      n_cmp++; if (m_out_keep !== 4'b1100) begin n_err++; $display("FAIL last_keep_msb got=%b exp=1100", m_out_keep); end
      drive(8'hCC, 1'b1); tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL one_lane_valid got=%b exp=1", out_valid); end
      n_cmp++; if (out_data !== 32'h000000CC) begin n_err++; $display("FAIL one_lane_data got=%h exp=000000cc", out_data); end
      n_cmp++; if (out_keep !== 4'b0001) begin n_err++; $display("FAIL one_lane_keep got=%b exp=0001", out_keep); end
      n_cmp++; if (m_out_data !== 32'hCC000000) begin n_err++; $display("FAIL one_lane_data_msb got=%h exp=cc000000", m_out_data); end
      n_cmp++; if (m_out_keep !== 4'b1000) begin n_err++; $display("FAIL one_lane_keep_msb got=%b exp=1000", m_out_keep); end
      in_valid = 1'b0; in_last = 1'b1; tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stray_last_valid got=%b exp=0", out_valid); end
      for (int i = 1; i <= 4; i++) begin
         drive(8'(i), 1'b0); tick();
      end
      idle();
      n_cmp++; if (out_data !== 32'h04030201) begin n_err++; $display("FAIL stray_last_data got=%h exp=04030201", out_data); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL stray_last_last got=%b exp=0", out_last); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(8'(i), 1'b0); tick();
      end
      n_cmp++; if (out_data !== 32'h04030201) begin n_err++; $display("FAIL bp_word1 got=%h exp=04030201", out_data); end
      for (int i = 5; i <= 7; i++) begin
         drive(8'(i), 1'b0);
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_beat%0d got=%b exp=1", i, in_ready); end
         tick();
      end
      drive(8'h08, 1'b0);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_beat8 got=%b exp=0", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin n_err++; $display("FAIL bp_hold got=%b/%h exp=1/04030201", out_valid, out_data); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_release got=%b exp=1", in_ready); end
      tick();
      idle(); out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_word2_valid got=%b exp=1", out_valid); end
      n_cmp++; if (out_data !== 32'h08070605) begin n_err++; $display("FAIL bp_word2 got=%h exp=08070605", out_data); end
      tick();
      n_cmp++; if (out_data !== 32'h08070605) begin n_err++; $display("FAIL bp_word2_hold got=%h exp=08070605", out_data); end
      out_ready = 1'b1; tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_words [3];
      int          exp_idx   [3];
      logic [31:0] got_words [3];
      int          got_idx   [3];
      int unsigned nvalid, rdy_drops;
      exp_words = '{32'hA4A3A2A1, 32'hA8A7A6A5, 32'hACABAAA9};
      exp_idx   = '{3, 7, 11};
      got_words = '{default: '0};
      got_idx   = '{default: -1};
      nvalid = 0; rdy_drops = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(8'hA1 + 8'(i), 1'b0);
         #1;
         if (in_ready !== 1'b1) rdy_drops++;
         tick();
         if (out_valid === 1'b1) begin
            if (nvalid < 3) begin
               got_words[nvalid] = out_data;
               got_idx[nvalid]   = i;
            end
            nvalid++;
         end
      end
      idle();
      n_cmp++; if (rdy_drops != 0) begin n_err++; $display("FAIL b2b_in_bubbles got=%0d exp=0", rdy_drops); end
      n_cmp++; if (nvalid != 3) begin n_err++; $display("FAIL b2b_word_count got=%0d exp=3", nvalid); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (got_words[k] !== exp_words[k]) begin n_err++; $display("FAIL b2b_word%0d got=%h exp=%h", k, got_words[k], exp_words[k]); end
         n_cmp++; if (got_idx[k] != exp_idx[k]) begin n_err++; $display("FAIL b2b_slot%0d got=%0d exp=%0d", k, got_idx[k], exp_idx[k]); end
      end
      tick();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(8'hAA, 1'b0); tick();
      drive(8'hBB, 1'b0); tick();
      drive(8'hCC, 1'b0); tick();
      drive(8'hDD, 1'b0); tick();
      drive(8'h55, 1'b0); tick();
      drive(8'h66, 1'b0); tick();
      idle();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pending got=%b exp=1", out_valid); end
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_data !== 32'h0 || out_keep !== 4'b0) begin n_err++; $display("FAIL arst_regs got=%h/%b exp=00000000/0000", out_data, out_keep); end
      @(posedge clk); #3 rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(8'(i), 1'b0); tick();
      end
      idle();
      n_cmp++; if (out_data !== 32'h04030201) begin n_err++; $display("FAIL arst_after got=%h exp=04030201", out_data); end
      n_cmp++; if (out_keep !== 4'b1111) begin n_err++; $display("FAIL arst_after_keep got=%b exp=1111", out_keep); end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_full_word();
      test_last();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
